// File: rtl/mouse_pos_latch.sv
// Clamps raw mouse coordinates, holds the latest sample, and commits it to the overlay
// at the start of vertical blanking; hides the cursor after a run of frames with no movement.
module mouse_pos_latch #(
  parameter int unsigned H_ACTIVE    = 800,
  parameter int unsigned V_ACTIVE    = 600,
  parameter int unsigned RESET_X     = 400,
  parameter int unsigned RESET_Y     = 300,
  parameter int unsigned IDLE_FRAMES = 300
) (
  input  logic        clk40MHz,
  input  logic        rst,
  input  logic [11:0] xpos_raw,
  input  logic [11:0] ypos_raw,
  input  logic        pos_valid,
  input  logic        vblnk,
  output logic [11:0] xpos,
  output logic [11:0] ypos,
  output logic        cursor_visible,
  output logic        pos_update
);

  localparam int unsigned CNT_W = (IDLE_FRAMES > 0) ? $clog2(IDLE_FRAMES + 1) : 1;
  localparam logic [11:0] X_MAX  = 12'(H_ACTIVE - 1);
  localparam logic [11:0] Y_MAX  = 12'(V_ACTIVE - 1);
  localparam logic [11:0] X_INIT = 12'(RESET_X);
  localparam logic [11:0] Y_INIT = 12'(RESET_Y);
  localparam logic [CNT_W-1:0] IDLE_LIMIT = CNT_W'(IDLE_FRAMES);

  logic [11:0]      pend_x, pend_y;
  logic             dirty;
  logic             vblnk_d;
  logic [CNT_W-1:0] idle_cnt;

  logic             frame_start_c;
  logic             commit_c;
  logic             idle_tick_c;
  logic [CNT_W-1:0] idle_next_c;
  logic [11:0]      clamp_x_c, clamp_y_c;

  // Next-state decode: frame edge, commit/idle decisions and input clamping.
  always_comb begin
    frame_start_c = 1'b0;
    commit_c      = 1'b0;
    idle_tick_c   = 1'b0;
    idle_next_c   = idle_cnt;
    clamp_x_c     = xpos_raw;
    clamp_y_c     = ypos_raw;

    frame_start_c = vblnk & ~vblnk_d;
    commit_c      = frame_start_c & dirty;

    if (IDLE_FRAMES != 0) begin
      idle_tick_c = frame_start_c & ~dirty & (idle_cnt < IDLE_LIMIT);
    end
    if (idle_tick_c) begin
      idle_next_c = idle_cnt + CNT_W'(1);
    end

    if (xpos_raw > X_MAX) begin
      clamp_x_c = X_MAX;
    end
    if (ypos_raw > Y_MAX) begin
      clamp_y_c = Y_MAX;
    end
  end

  // State and output registers; commit reads pend from before this edge.
  always_ff @(posedge clk40MHz or posedge rst) begin
    if (rst) begin
      xpos           <= X_INIT;
      ypos           <= Y_INIT;
      cursor_visible <= 1'b1;
      pos_update     <= 1'b0;
      pend_x         <= X_INIT;
      pend_y         <= Y_INIT;
      dirty          <= 1'b0;
      idle_cnt       <= '0;
      vblnk_d        <= 1'b0;
    end else begin
      vblnk_d    <= vblnk;
      pos_update <= commit_c;

      if (commit_c) begin
        xpos           <= pend_x;
        ypos           <= pend_y;
        idle_cnt       <= '0;
        cursor_visible <= 1'b1;
      end else if (idle_tick_c) begin
        idle_cnt <= idle_next_c;
        if (idle_next_c == IDLE_LIMIT) begin
          cursor_visible <= 1'b0;
        end
      end

      // A sample arriving on a commit cycle keeps dirty set for the next frame.
      if (pos_valid) begin
        pend_x <= clamp_x_c;
        pend_y <= clamp_y_c;
        dirty  <= 1'b1;
      end else if (commit_c) begin
        dirty <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mouse_pos_latch.sv
// Bench for mouse_pos_latch: directed scenarios with literal expectations plus a randomized
// run, all compared every cycle against a frame-level behavioural model.
module tb_mouse_pos_latch;

  localparam int IDLE = 3;

  logic        clk40MHz = 1'b0;
  logic        rst = 1'b0;
  logic [11:0] xpos_raw = '0;
  logic [11:0] ypos_raw = '0;
  logic        pos_valid = 1'b0;
  logic        vblnk = 1'b0;
  logic [11:0] xpos, ypos;
  logic        cursor_visible, pos_update;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  mouse_pos_latch #(
    .H_ACTIVE(800), .V_ACTIVE(600), .RESET_X(400), .RESET_Y(300), .IDLE_FRAMES(IDLE)
  ) dut (
    .clk40MHz(clk40MHz), .rst(rst), .xpos_raw(xpos_raw), .ypos_raw(ypos_raw),
    .pos_valid(pos_valid), .vblnk(vblnk), .xpos(xpos), .ypos(ypos),
    .cursor_visible(cursor_visible), .pos_update(pos_update)
  );

  always #5 clk40MHz = ~clk40MHz;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic int clampv(input int v, input int lim);
    return (v > lim - 1) ? lim - 1 : v;
  endfunction

  // Model: latest clamped sample waits for a rising vblank; visibility follows frames-since-commit.
  int m_x, m_y, m_px, m_py, m_idle;
  bit m_dirty, m_upd, m_prev_vb;

  always @(posedge clk40MHz or posedge rst) begin
    if (rst) begin
      m_x = 400; m_y = 300; m_px = 400; m_py = 300;
      m_dirty = 0; m_upd = 0; m_idle = 0; m_prev_vb = 0;
    end else begin
      m_upd = 0;
      if (vblnk && !m_prev_vb) begin
        if (m_dirty) begin
          m_x = m_px; m_y = m_py; m_upd = 1; m_idle = 0; m_dirty = 0;
        end else if (m_idle < IDLE) begin
          m_idle++;
        end
      end
      if (pos_valid) begin
        m_px = clampv(int'(xpos_raw), 800);
        m_py = clampv(int'(ypos_raw), 600);
        m_dirty = 1;
      end
      m_prev_vb = vblnk;
    end
  end

  always @(negedge clk40MHz) begin
    if (cmp_en) begin
      chk("model_xpos", int'(xpos), m_x);
      chk("model_ypos", int'(ypos), m_y);
      chk("model_visible", int'(cursor_visible), (m_idle < IDLE) ? 1 : 0);
      chk("model_pos_update", int'(pos_update), int'(m_upd));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk40MHz);
  endtask

  task automatic sample(input int x, input int y);
    pos_valid = 1'b1; xpos_raw = 12'(x); ypos_raw = 12'(y);
    @(negedge clk40MHz);
    pos_valid = 1'b0;
  endtask

  task automatic rise();
    vblnk = 1'b1;
    @(negedge clk40MHz);
  endtask

  task automatic fall();
    cyc(2);
    vblnk = 1'b0;
    cyc(3);
  endtask

  initial begin
    #1 rst = 1'b1;
    cmp_en = 1'b1;
    cyc(2);
    chk("reset_xpos", int'(xpos), 400);
    chk("reset_ypos", int'(ypos), 300);
    chk("reset_visible", int'(cursor_visible), 1);
    chk("reset_update", int'(pos_update), 0);
    rst = 1'b0;
    cyc(3);

    // Mid-frame sample stays pending until vblank rises.
    sample(123, 45);
    cyc(3);
    chk("hold_xpos", int'(xpos), 400);
    rise();
    chk("commit_xpos", int'(xpos), 123);
    chk("commit_ypos", int'(ypos), 45);
    chk("commit_pulse", int'(pos_update), 1);
    @(negedge clk40MHz);
    chk("pulse_single", int'(pos_update), 0);
    fall();

    // Clamp, and an in-range maximum passes through.
    sample(900, 4000);
    rise();
    chk("clamp_xpos", int'(xpos), 799);
    chk("clamp_ypos", int'(ypos), 599);
    fall();
    sample(799, 599);
    rise();
    chk("edge_xpos", int'(xpos), 799);
    chk("edge_update", int'(pos_update), 1);
    fall();

    // Sample on the frame_start cycle waits for the following frame.
    sample(20, 20);
    cyc(2);
    vblnk = 1'b1; pos_valid = 1'b1; xpos_raw = 12'd10; ypos_raw = 12'd10;
    @(negedge clk40MHz);
    pos_valid = 1'b0;
    chk("coincident_x_old", int'(xpos), 20);
    fall();
    rise();
    chk("coincident_x_new", int'(xpos), 10);
    chk("coincident_y_new", int'(ypos), 10);
    fall();

    // Idle hiding after three quiet frames, restored by the next commit.
    rise(); fall();
    rise();
    chk("idle2_visible", int'(cursor_visible), 1);
    fall();
    rise();
    chk("idle3_hidden", int'(cursor_visible), 0);
    fall();
    rise();
    chk("idle4_hidden", int'(cursor_visible), 0);
    fall();
    sample(50, 60);
    rise();
    chk("restore_visible", int'(cursor_visible), 1);
    chk("restore_xpos", int'(xpos), 50);

    // Reset mid-vblank with a pending sample discards it.
    cyc(1);
    sample(70, 80);
    #2 rst = 1'b1;
    #1;
    chk("async_xpos", int'(xpos), 400);
    chk("async_visible", int'(cursor_visible), 1);
    @(negedge clk40MHz);
    rst = 1'b0;
    @(negedge clk40MHz);
    chk("post_reset_no_commit", int'(pos_update), 0);
    chk("post_reset_xpos", int'(xpos), 400);
    fall();
    rise();
    chk("post_reset_frame_xpos", int'(xpos), 400);
    chk("post_reset_frame_update", int'(pos_update), 0);
    fall();

    // Randomized run: busy movement first, then sparse movement to exercise hiding.
    for (int i = 0; i < 4000; i++) begin
      int ph;
      int rate;
      ph = i % 40;
      rate = (i < 2000) ? 8 : 250;
      vblnk = (ph >= 33);
      pos_valid = ($urandom % rate) == 0;
      xpos_raw = ($urandom % 3 == 0) ? 12'($urandom) : 12'($urandom_range(0, 799));
      ypos_raw = ($urandom % 3 == 0) ? 12'($urandom) : 12'($urandom_range(0, 599));
      if ($urandom % 1500 == 0) begin
        rst = 1'b1;
        @(negedge clk40MHz);
        rst = 1'b0;
      end else begin
        @(negedge clk40MHz);
      end
    end
    pos_valid = 1'b0;
    cyc(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
